mult_adder_seq: RTL
===================

# mult_adder_seq

Sequential 128-lane sign-magnitude dot-product engine. It is the responder on the operand/result interface driven by the fully-connected layer controllers: it captures two 1024-bit vectors of 128 8-bit operands, multiplies lane-wise, and accumulates the products over several cycles. It returns a 15-bit sign-magnitude sum plus an overflow flag under a start/valid handshake. This replaces a single-cycle combinational multiply-adder to relieve timing on the 128-lane sum.

## Interface
- LANES, 8, products accumulated per cycle. Legal values are 1, 2, 4, 8 and 16. CHUNKS = 128/LANES.
- clk  in  1  clock; all state updates on the rising edge.
- iRst_n  in  1  reset, synchronous, active-low.
- ena  in  1  clock enable. When low, all state and outputs hold.
- start  in  1  request pulse. Sampled only in IDLE.
- opr1  in  1024  activations. Lane i is opr1[8i+7:8i].
- opr2  in  1024  weights. Lane i is opr2[8i+7:8i].
- busy  out  1  high while an operation is in flight.
- valid  out  1  one-cycle pulse; result and overflow are valid in this cycle.
- result  out  15  sign-magnitude sum: bit14 is the sign, [13:0] is the Q0.14 magnitude.
- overflow  out  1  high when the true sum magnitude exceeds 16383.

## Operation
- Operand format: bit7 is the sign, [6:0] is the Q0.7 magnitude.
- Product: sign = s1^s2, magnitude = m1*m2 (14 bits). A zero-magnitude product is +0.
- Accumulator: 22-bit two's complement, cleared on start. The worst case, 128*16129 = 2,064,512, never wraps.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 registers opr1 and opr2 into internal copies, clears the accumulator and sets chunk=0.
  - Go to RUN; busy=1.
- RUN:
  - Each enabled cycle adds the signed products of lanes chunk*LANES .. chunk*LANES+LANES-1, then does chunk++.
  - After adding chunk CHUNKS-1, go to FIN.
- FIN:
  - Convert the accumulator to sign-magnitude. If |acc| > 16383, result = {sign, 14'h3FFF} and overflow=1. Otherwise result = {sign, |acc|} and overflow=0.
  - acc == 0 gives result 15'h0000 with sign 0.
  - valid=1 and busy=0 for one cycle; go to IDLE.
- result and overflow hold their last value until the next FIN.
- Operands are used only from the internal copies, so the initiator may change opr1/opr2 any time after start is accepted.
- start while busy=1 is ignored. It is not queued.
- start in the same cycle valid is high is accepted, because the state is already IDLE; this allows back-to-back operations.
- ena low in any state freezes state, chunk, accumulator and outputs. A pending valid stays high until the next enabled edge.
- Reset has priority over ena.

## Timing
- Reset values: busy=0, valid=0, result=15'h0000, overflow=0, state IDLE, accumulator 0.
- Reset mid-RUN or mid-FIN aborts the operation: no valid is produced and the next cycle is IDLE.
- With start sampled at edge N (ena held high):
  - busy=1 after edge N.
  - Accumulation happens on edges N+1 .. N+CHUNKS.
  - valid=1 and busy=0 after edge N+CHUNKS+1.
- Latency is CHUNKS+1 cycles (17 for LANES=8). Each cycle of ena=0 adds one cycle.
- valid is never high for two consecutive enabled cycles.

## Test plan
- All-zero operands, start once → valid after 17 cycles, result=15'h0000, overflow=0, busy high exactly 16 cycles.
- Lane 5: opr1=8'h40, opr2=8'hC0; other lanes zero → result=15'h5000 (−4096), overflow=0.
- Lane 0 = +0x40×+0x40 and lane 127 = −0x40×+0x40 → result=15'h0000 (sign cleared), overflow=0.
- All lanes 8'h7F×8'h7F → result=15'h3FFF, overflow=1. Repeat with opr1 all 8'hFF → result=15'h7FFF, overflow=1.
- Second start mid-RUN, opr1 changed after acceptance, and ena low for 3 cycles mid-RUN → single valid at latency 20, result from the originally captured operands. Back-to-back start in the valid cycle → accepted.
- iRst_n low at RUN chunk 7 → no valid, outputs zero, next start completes normally with the correct result.

Source files
------------

// File: rtl/mult_adder_seq.sv
// Sequential sign-magnitude dot product of 128 8-bit lanes, LANES products per cycle.
// Returns a saturated 15-bit sign-magnitude sum with an overflow flag.
module mult_adder_seq #(
  parameter int unsigned LANES = 8
) (
  input  logic          clk,
  input  logic          iRst_n,
  input  logic          ena,
  input  logic          start,
  input  logic [1023:0] opr1,
  input  logic [1023:0] opr2,
  output logic          busy,
  output logic          valid,
  output logic [14:0]   result,
  output logic          overflow
);

  localparam int unsigned CHUNKS = 128 / LANES;
  localparam int unsigned CW     = $clog2(CHUNKS);
  localparam int unsigned AW     = 22;
  localparam int unsigned SHIFT  = 8 * LANES;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   chunk;
  logic [AW-1:0]   acc;
  logic [1023:0]   r1;
  logic [1023:0]   r2;
  logic [AW-1:0]   chunk_sum;
  logic [AW-1:0]   acc_mag;
  logic            acc_ovf;

  // Signed product of two sign-magnitude operands; zero magnitude is always +0.
  function automatic logic [AW-1:0] lane_prod(input logic [7:0] a, input logic [7:0] b);
    logic [13:0] mag;
    mag = {7'b0, a[6:0]} * {7'b0, b[6:0]};
    if ((a[7] ^ b[7]) && (mag != 14'd0))
      lane_prod = -{8'b0, mag};
    else
      lane_prod = {8'b0, mag};
  endfunction

  // The operand copies shift down each chunk, so the current chunk is always lanes 0..LANES-1.
  always_comb begin
    chunk_sum = '0;
    for (int j = 0; j < int'(LANES); j++)
      chunk_sum = chunk_sum + lane_prod(r1[8*j +: 8], r2[8*j +: 8]);
  end

  always_comb begin
    acc_mag = acc[AW-1] ? -acc : acc;
    acc_ovf = (acc_mag > AW'(16383));
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state    <= IDLE;
      chunk    <= '0;
      acc      <= '0;
      r1       <= '0;
      r2       <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      result   <= 15'h0000;
      overflow <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            r1    <= opr1;
            r2    <= opr2;
            acc   <= '0;
            chunk <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc + chunk_sum;
          r1    <= r1 >> SHIFT;
          r2    <= r2 >> SHIFT;
          chunk <= chunk + CW'(1);
          if (chunk == CW'(CHUNKS - 1)) begin
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          // Magnitudes beyond 14 bits saturate; a zero sum has a zero sign bit.
          if (acc_ovf) begin
            result   <= {acc[AW-1], 14'h3FFF};
            overflow <= 1'b1;
          end else begin
            result   <= {acc[AW-1], acc_mag[13:0]};
            overflow <= 1'b0;
          end
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
